// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared stopwatch mode encodings, button indices and event priority
package stopwatch_pkg;

  typedef enum logic [2:0] {
    ST_RESET = 3'b001,
    ST_COUNT = 3'b010,
    ST_PAUSE = 3'b011,
    ST_STOP  = 3'b100
  } state_t;

  typedef enum logic [2:0] {
    EV_NONE,
    EV_COUNT,
    EV_PAUSE,
    EV_STOP,
    EV_RESET
  } event_t;

  localparam int DEBOUNCE_CYCLES_DEFAULT = 500000;

  localparam int BTN_START = 0;
  localparam int BTN_COUNT = 1;
  localparam int BTN_PAUSE = 2;
  localparam int BTN_STOP  = 3;
  localparam int BTN_RESET = 4;
  localparam int NUM_BTNS  = 5;

  // Only the strongest simultaneous press is acted on: Reset > Stop > Pause > Count.
  function automatic event_t prio_event(input logic [NUM_BTNS-1:0] press);
    if (press[BTN_RESET])      return EV_RESET;
    else if (press[BTN_STOP])  return EV_STOP;
    else if (press[BTN_PAUSE]) return EV_PAUSE;
    else if (press[BTN_COUNT]) return EV_COUNT;
    else                       return EV_NONE;
  endfunction

endpackage

// File: rtl/stopwatch_button_fsm_if.sv
// rtl/stopwatch_button_fsm_if.sv - raw board buttons in, stopwatch mode code out
interface stopwatch_button_fsm_if;

  logic       ButtonStart;
  logic       ButtonReset;
  logic       ButtonCount;
  logic       ButtonPause;
  logic       ButtonStop;
  logic [2:0] state;
  logic       state_changed;

  modport master (
    output ButtonStart, ButtonReset, ButtonCount, ButtonPause, ButtonStop,
    input  state, state_changed
  );

  modport slave (
    input  ButtonStart, ButtonReset, ButtonCount, ButtonPause, ButtonStop,
    output state, state_changed
  );

endinterface

// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - 2-flop synchronizer, stability counter, debounced level and rise pulse
module button_debounce
  import stopwatch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_raw,
  output logic o_level,
  output logic o_rise
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] TERM = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic          r_level_d;
  logic          r_rise;
  logic [CW-1:0] r_cnt;

  // The counter only runs while the synchronized input disagrees with the
  // debounced level, so any bounce back restarts the stability window.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
      r_rise    <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_sync1   <= i_raw;
      r_sync2   <= r_sync1;
      r_level_d <= r_level;
      r_rise    <= r_level & ~r_level_d;
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == TERM) begin
        r_level <= r_sync2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_level = r_level;
  assign o_rise  = r_rise;

endmodule

// File: rtl/stopwatch_button_fsm.sv
// rtl/stopwatch_button_fsm.sv - debounced button front end and stopwatch mode state machine
module stopwatch_button_fsm
  import stopwatch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  stopwatch_button_fsm_if.slave  bus
);

  logic [NUM_BTNS-1:0] w_raw;
  logic [NUM_BTNS-1:0] w_level;
  logic [NUM_BTNS-1:0] w_rise;
  logic                w_enable;
  logic                w_unused;
  event_t              w_event;
  state_t              w_next;
  state_t              r_state;
  logic                r_changed;

  assign w_raw[BTN_START] = bus.ButtonStart;
  assign w_raw[BTN_COUNT] = bus.ButtonCount;
  assign w_raw[BTN_PAUSE] = bus.ButtonPause;
  assign w_raw[BTN_STOP]  = bus.ButtonStop;
  assign w_raw[BTN_RESET] = bus.ButtonReset;

  for (genvar g = 0; g < NUM_BTNS; g++) begin : g_btn
    button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_raw   (w_raw[g]),
      .o_level (w_level[g]),
      .o_rise  (w_rise[g])
    );
  end

  // Start is a run-enable level switch; only the push-buttons are edge events.
  assign w_enable = w_level[BTN_START];
  assign w_event  = prio_event(w_rise);
  assign w_unused = ^w_level[NUM_BTNS-1:1];

  always_comb begin
    w_next = r_state;
    if (!w_enable) begin
      w_next = ST_RESET;
    end else begin
      case (r_state)
        ST_RESET: begin
          if (w_event == EV_COUNT) w_next = ST_COUNT;
        end
        ST_COUNT: begin
          case (w_event)
            EV_PAUSE: w_next = ST_PAUSE;
            EV_STOP:  w_next = ST_STOP;
            EV_RESET: w_next = ST_RESET;
            default:  w_next = r_state;
          endcase
        end
        ST_PAUSE: begin
          case (w_event)
            EV_COUNT: w_next = ST_COUNT;
            EV_PAUSE: w_next = ST_COUNT;
            EV_STOP:  w_next = ST_STOP;
            EV_RESET: w_next = ST_RESET;
            default:  w_next = r_state;
          endcase
        end
        ST_STOP: begin
          if (w_event == EV_RESET) w_next = ST_RESET;
        end
        default: w_next = ST_RESET;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_RESET;
      r_changed <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_changed <= (w_next != r_state);
    end
  end

  assign bus.state         = r_state;
  assign bus.state_changed = r_changed;

endmodule

// File: tb/tb_stopwatch_button_fsm.sv
// tb/tb_stopwatch_button_fsm.sv - scoreboard bench for the stopwatch button front end
module tb_stopwatch_button_fsm;
  import stopwatch_pkg::*;

  localparam int LAT_PRESS = 8;
  localparam int LAT_START = 7;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  stopwatch_button_fsm_if u_if ();

  stopwatch_button_fsm #(
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if)
  );

  typedef struct {
    logic [2:0] st;
    int         at;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b0 && u_if.state_changed === 1'b1) begin
      n_vec++;
      if (q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_pulse cyc=%0d state=%b required=no_pulse", cyc, u_if.state);
      end else begin
        e = q.pop_front();
        if (u_if.state !== e.st) begin
          n_bad++;
          $display("FAIL pulse_state cyc=%0d got=%b required=%b", cyc, u_if.state, e.st);
        end
        n_vec++;
        if (cyc != e.at) begin
          n_bad++;
          $display("FAIL pulse_cycle got=%0d required=%0d", cyc, e.at);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_change(input logic [2:0] st, input int lat);
    exp_t e;
    e.st = st;
    e.at = cyc + lat;
    q.push_back(e);
  endtask

  task automatic set_btn(input int b, input logic v);
    case (b)
      BTN_START: u_if.ButtonStart = v;
      BTN_COUNT: u_if.ButtonCount = v;
      BTN_PAUSE: u_if.ButtonPause = v;
      BTN_STOP:  u_if.ButtonStop  = v;
      default:   u_if.ButtonReset = v;
    endcase
  endtask

  task automatic press(input int b, input logic changes, input logic [2:0] st);
    if (changes) expect_change(st, LAT_PRESS);
    set_btn(b, 1'b1);
    tick(10);
    set_btn(b, 1'b0);
    tick(10);
  endtask

  task automatic check(input string name, input logic [2:0] got, input logic [2:0] req);
    n_vec++;
    if (got !== req) begin
      n_bad++;
      $display("FAIL %s got=%b required=%b", name, got, req);
    end
  endtask

  initial begin
    int budget;
    rst = 1'b1;
    u_if.ButtonStart = 1'b1;
    u_if.ButtonReset = 1'b0;
    u_if.ButtonCount = 1'b0;
    u_if.ButtonPause = 1'b0;
    u_if.ButtonStop  = 1'b0;
    tick(3);
    check("reset_state", u_if.state, 3'b001);
    check("reset_changed", {2'b00, u_if.state_changed}, 3'b000);
    rst = 1'b0;
    tick(12);
    check("idle_state", u_if.state, 3'b001);

    press(BTN_COUNT, 1'b1, ST_COUNT);
    check("after_count", u_if.state, 3'b010);

    // Bouncy Pause: two short highs must be rejected, only the final hold counts.
    for (int i = 0; i < 2; i++) begin
      set_btn(BTN_PAUSE, 1'b1);
      tick(2);
      set_btn(BTN_PAUSE, 1'b0);
      tick(2);
    end
    press(BTN_PAUSE, 1'b1, ST_PAUSE);
    check("after_bounce", u_if.state, 3'b011);

    press(BTN_PAUSE, 1'b1, ST_COUNT);
    press(BTN_PAUSE, 1'b1, ST_PAUSE);

    expect_change(ST_RESET, LAT_PRESS);
    u_if.ButtonStop  = 1'b1;
    u_if.ButtonReset = 1'b1;
    tick(10);
    u_if.ButtonStop  = 1'b0;
    u_if.ButtonReset = 1'b0;
    tick(10);
    check("simul_reset_wins", u_if.state, 3'b001);

    press(BTN_RESET, 1'b0, ST_RESET);
    press(BTN_COUNT, 1'b1, ST_COUNT);
    press(BTN_STOP, 1'b1, ST_STOP);
    press(BTN_COUNT, 1'b0, ST_STOP);
    press(BTN_PAUSE, 1'b0, ST_STOP);
    check("stop_sticky", u_if.state, 3'b100);
    press(BTN_RESET, 1'b1, ST_RESET);
    press(BTN_COUNT, 1'b1, ST_COUNT);

    expect_change(ST_RESET, LAT_START);
    u_if.ButtonStart = 1'b0;
    tick(10);
    press(BTN_COUNT, 1'b0, ST_RESET);
    check("start_low_ignores", u_if.state, 3'b001);
    u_if.ButtonStart = 1'b1;
    tick(10);

    press(BTN_COUNT, 1'b1, ST_COUNT);
    press(BTN_PAUSE, 1'b1, ST_PAUSE);

    // Count half-debounced when rst hits; it must restart from scratch afterwards.
    u_if.ButtonCount = 1'b1;
    tick(4);
    rst = 1'b1;
    tick(3);
    check("midrst_state", u_if.state, 3'b001);
    check("midrst_changed", {2'b00, u_if.state_changed}, 3'b000);
    expect_change(ST_COUNT, LAT_PRESS);
    rst = 1'b0;
    tick(2);
    check("post_rst_state", u_if.state, 3'b001);
    tick(10);
    u_if.ButtonCount = 1'b0;
    tick(10);
    check("post_rst_count", u_if.state, 3'b010);

    budget = 50;
    while (q.size() != 0 && budget > 0) begin
      tick(1);
      budget--;
    end
    n_vec++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL pending_expected got=%0d required=0", q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/stopwatch_button_fsm.md
# stopwatch_button_fsm

Front-end control stage of the digital stopwatch. It synchronizes and debounces the five raw board push-buttons, detects press edges, and runs the mode state machine. It drives the 3-bit mode code consumed by the stopwatch counting/display core (RESET 001, COUNT 010, PAUSE 011, STOP 100). It replaces direct use of raw button levels, so the core sees exactly one clean, single-cycle-resolved mode change per press.

## Interface
Parameters:
- DEBOUNCE_CYCLES, default 500000 (10 ms at 50 MHz): consecutive stable cycles required before a debounced level changes. Legal range 2 to 2^24−1.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- ButtonStart  in  1  raw run-enable switch, asynchronous, active-high.
- ButtonReset  in  1  raw push-button, asynchronous, active-high.
- ButtonCount  in  1  raw push-button, asynchronous, active-high.
- ButtonPause  in  1  raw push-button, asynchronous, active-high.
- ButtonStop  in  1  raw push-button, asynchronous, active-high.
- state  out  3  registered mode code: 001 RESET, 010 COUNT, 011 PAUSE, 100 STOP. No other value is ever driven.
- state_changed  out  1  registered one-cycle pulse, asserted in the first cycle `state` holds a new value.

## Operation
- Each input passes through a 2-flop synchronizer, then a debouncer.
- Debouncer behaviour:
  - A counter increments on every edge where the synchronized level differs from the debounced level.
  - The counter clears on any edge where they are equal.
  - On the edge where the counter is DEBOUNCE_CYCLES−1 and the levels still differ, the debounced level flips and the counter clears.
- Press event: a registered one-cycle pulse on each debounced 0→1 transition. Releases generate no event.
- Start enable is the debounced ButtonStart level. While the enable is 0:
  - `state` is forced to RESET on every edge.
  - All press events are discarded.
- Event priority when several events arrive on the same edge: Reset > Stop > Pause > Count. Only the highest-priority event is applied.
- Transitions (any event not listed leaves `state` unchanged):
  - RESET: Count → COUNT.
  - COUNT: Pause → PAUSE; Stop → STOP; Reset → RESET.
  - PAUSE: Count → COUNT; Pause → COUNT (toggle resume); Stop → STOP; Reset → RESET.
  - STOP: Reset → RESET. Count and Pause are ignored; a reset is required before a new run.
- `state_changed` pulses only when the next state differs from the current one. Events that leave `state` unchanged (e.g. Reset while in RESET) produce no pulse.
- Reset values (rst=1): `state`=001, `state_changed`=0, all synchronizer flops 0, debounced levels 0, counters 0, event pulses 0.
- Reset mid-debounce aborts that debounce. A button still held after rst deasserts is debounced from scratch, and its press event fires once the button is stable, as for a new press.

## Timing
- Raw input sampled high at edge k:
  - debounced level flips at edge k+1+DEBOUNCE_CYCLES;
  - press pulse is high in the cycle after edge k+2+DEBOUNCE_CYCLES;
  - `state` and `state_changed` update at edge k+3+DEBOUNCE_CYCLES.
- Total latency from input to `state` is DEBOUNCE_CYCLES+3 edges.
- Glitches shorter than DEBOUNCE_CYCLES synchronized cycles produce no event.
- ButtonStart going low: `state` is RESET at edge k+2+DEBOUNCE_CYCLES, with a `state_changed` pulse if `state` was not already RESET.
- Counter width: clog2(DEBOUNCE_CYCLES). The counter never wraps, because it clears at terminal count.

## Structure
- Shared package stopwatch_pkg holds:
  - the state encodings ST_RESET, ST_COUNT, ST_PAUSE, ST_STOP (3-bit);
  - the default DEBOUNCE_CYCLES constant.
  The counting core imports the same package.
- Sub-module `button_debounce` (2-flop synchronizer, debounce counter, debounced level, registered rise pulse). It is instantiated five times. The top level holds only the priority encoder and the mode FSM.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4.
- Reset value: hold rst for 3 cycles → `state`=001, `state_changed`=0. Release rst with ButtonStart=1 stable → `state` remains 001.
- Basic press: ButtonStart=1 debounced; raise ButtonCount at edge k and hold → `state`=010 at edge k+7, `state_changed` high for exactly one cycle; releasing the button causes no change.
- Bounce rejection: in COUNT, toggle ButtonPause 1,0,1,0 every 2 cycles, then hold it high → exactly one PAUSE transition, occurring 7 edges after the final rise.
- Simultaneous events: in PAUSE, raise ButtonStop and ButtonReset on the same edge → `state`=001 (Reset wins), one `state_changed` pulse. In STOP, press Count → `state` stays 100, no pulse.
- Start disable: in COUNT, drop ButtonStart → `state`=001 six edges later. Press Count while Start is low → no change.
- Reset mid-operation: assert rst during PAUSE while ButtonCount is half-debounced (counter = 2) → after release, `state`=001. Keep Count held → `state`=010 seven edges after rst deasserts.
